// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// Handles multi-cycle data-memory waits (req/ack), load-use bubbles and
// taken-branch flushes, and latches a sticky error on a memory timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds two saturating 32-bit
// performance counters (memory-stall cycles and load-use bubbles).
//
// Outputs are combinational from the registered state and the current inputs,
// so every stall/flush takes effect in the cycle the hazard is seen. While
// rst is high all outputs are forced low.
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W    = 5,
   parameter int BUBBLE_CYCLES = 1,   // 1..7
   parameter int MEM_TIMEOUT   = 15   // 1..255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_req,
   input  logic                  mem_ack,
   input  logic                  branch_taken,
   output logic                  stall_if_id,
   output logic                  stall_id_ex,
   output logic                  stall_ex_mem,
   output logic                  stall_mem_wb,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  pc_hold,
   output logic                  mem_timeout_err,
   output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_mem_stall,
   output logic [31:0]           perf_lu_bubble
`endif
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LOAD_USE = 2'b01,
      ST_MEM_WAIT = 2'b10,
      ST_ERR      = 2'b11
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] bubble_q, bubble_d;
   logic [7:0] wait_q, wait_d;

   logic lu_hit;
   logic memstall;
   logic run_hazards;
   logic s_all, s_bubble, s_flush, s_err;

   // Load-use hit: the load in EX writes a register the ID instruction reads.
   assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // A memory access that is not completing this cycle stalls the whole pipe.
   assign memstall = (state_q == ST_MEM_WAIT) ? ~mem_ack :
                     ((state_q != ST_ERR) && mem_req && ~mem_ack);

   // Next-state and raw output decode; s_* select an output pattern.
   always_comb begin
      state_d     = state_q;
      bubble_d    = bubble_q;
      wait_d      = wait_q;
      run_hazards = 1'b0;
      s_all       = 1'b0;
      s_bubble    = 1'b0;
      s_flush     = 1'b0;
      s_err       = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (memstall) begin
               s_all   = 1'b1;
               state_d = ST_MEM_WAIT;
               wait_d  = 8'd1;
            end else begin
               run_hazards = 1'b1;
            end
         end
         ST_LOAD_USE: begin
            if (memstall) begin
               // Memory wait wins; the remaining bubbles are dropped.
               s_all    = 1'b1;
               state_d  = ST_MEM_WAIT;
               wait_d   = 8'd1;
               bubble_d = 3'd0;
            end else begin
               s_bubble = 1'b1;
               if (bubble_q <= 3'd1) begin
                  state_d  = ST_RUN;
                  bubble_d = 3'd0;
               end else begin
                  bubble_d = bubble_q - 3'd1;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_ack) begin
               s_all = 1'b1;
               if (wait_q == 8'(MEM_TIMEOUT)) begin
                  state_d = ST_ERR;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end else begin
               // Pipe moves again this cycle; a branch or load-use that was
               // held behind the access is acted on now.
               state_d     = ST_RUN;
               wait_d      = 8'd0;
               run_hazards = 1'b1;
            end
         end
         default: begin
            s_all = 1'b1;
            s_err = 1'b1;
         end
      endcase

      if (run_hazards) begin
         if (branch_taken) begin
            s_flush = 1'b1;
         end else if (lu_hit) begin
            s_bubble = 1'b1;
            if (BUBBLE_CYCLES > 1) begin
               state_d  = ST_LOAD_USE;
               bubble_d = 3'(BUBBLE_CYCLES - 1);
            end
         end
      end
   end

   // Output drive, all forced low during reset.
   assign stall_if_id     = ~rst & (s_all | s_bubble);
   assign stall_id_ex     = ~rst & s_all;
   assign stall_ex_mem    = ~rst & s_all;
   assign stall_mem_wb    = ~rst & s_all;
   assign flush_if_id     = ~rst & s_flush;
   assign flush_id_ex     = ~rst & (s_flush | s_bubble);
   assign pc_hold         = ~rst & (s_all | s_bubble);
   assign mem_timeout_err = ~rst & s_err;
   assign ctrl_state      = rst ? 2'b00 : state_q;

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         bubble_q <= 3'd0;
         wait_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         bubble_q <= bubble_d;
         wait_q   <= wait_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_mem_q, perf_lu_q;

   // Saturating counters of memory-stall cycles and load-use bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_mem_q <= 32'd0;
         perf_lu_q  <= 32'd0;
      end else begin
         if (stall_mem_wb && (perf_mem_q != 32'hFFFF_FFFF)) begin
            perf_mem_q <= perf_mem_q + 32'd1;
         end
         if (flush_id_ex && !branch_taken && (perf_lu_q != 32'hFFFF_FFFF)) begin
            perf_lu_q <= perf_lu_q + 32'd1;
         end
      end
   end

   assign perf_mem_stall = perf_mem_q;
   assign perf_lu_bubble = perf_lu_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. Two instances share the stimulus: u_dut1 with
// BUBBLE_CYCLES=1 and u_dut3 with BUBBLE_CYCLES=3 (both MEM_TIMEOUT=15).
// Each scenario builds a table of steps; a step is driven just after a
// posedge, its expected output vector is pushed to exp_q, and at the
// following negedge the vector is popped and compared with the DUT outputs.
// Output vector: {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
//                 flush_if_id, flush_id_ex, pc_hold, mem_timeout_err,
//                 ctrl_state[1:0]}
module tb_hazard_stall_ctrl;

   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_ALL  = 7'b1111001;
   localparam logic [6:0] C_BUB  = 7'b1000011;
   localparam logic [6:0] C_FLU  = 7'b0000110;
   localparam logic [1:0] S_RUN  = 2'b00;
   localparam logic [1:0] S_LU   = 2'b01;
   localparam logic [1:0] S_MW   = 2'b10;
   localparam logic [1:0] S_ERR  = 2'b11;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       urt;
      logic       mr;
      logic       req;
      logic       ack;
      logic       br;
      logic [9:0] exp;
   } step_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_uses_rt, ex_mem_read, mem_req, mem_ack, branch_taken;

   logic sif1, sid1, sex1, smw1, fif1, fid1, ph1, err1;
   logic sif3, sid3, sex3, smw3, fif3, fid3, ph3, err3;
   logic [1:0] st1, st3;
   logic [9:0] got1, got3;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] pms1, plb1, pms3, plb3;
`endif

   assign got1 = {sif1, sid1, sex1, smw1, fif1, fid1, ph1, err1, st1};
   assign got3 = {sif3, sid3, sex3, smw3, fif3, fid3, ph3, err3, st3};

   logic [9:0] exp_q[$];
   int n_pass  = 0;
   int n_total = 0;

   hazard_stall_ctrl #(.REG_ADDR_W(5), .BUBBLE_CYCLES(1), .MEM_TIMEOUT(15)) u_dut1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_req(mem_req), .mem_ack(mem_ack),
      .branch_taken(branch_taken), .stall_if_id(sif1), .stall_id_ex(sid1),
      .stall_ex_mem(sex1), .stall_mem_wb(smw1), .flush_if_id(fif1), .flush_id_ex(fid1),
      .pc_hold(ph1), .mem_timeout_err(err1), .ctrl_state(st1)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_mem_stall(pms1), .perf_lu_bubble(plb1)
`endif
   );

   hazard_stall_ctrl #(.REG_ADDR_W(5), .BUBBLE_CYCLES(3), .MEM_TIMEOUT(15)) u_dut3 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_req(mem_req), .mem_ack(mem_ack),
      .branch_taken(branch_taken), .stall_if_id(sif3), .stall_id_ex(sid3),
      .stall_ex_mem(sex3), .stall_mem_wb(smw3), .flush_if_id(fif3), .flush_id_ex(fid3),
      .pc_hold(ph3), .mem_timeout_err(err3), .ctrl_state(st3)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_mem_stall(pms3), .perf_lu_bubble(plb3)
`endif
   );

   function automatic step_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic urt, input logic mr,
                                input logic req, input logic ack, input logic br,
                                input logic [6:0] ctl, input logic er, input logic [1:0] st);
      step_t s;
      s.rst = r; s.rs = rs; s.rt = rt; s.rd = rd; s.urt = urt; s.mr = mr;
      s.req = req; s.ack = ack; s.br = br;
      s.exp = {ctl, er, st};
      return s;
   endfunction

   function automatic step_t idle(input logic [1:0] st);
      return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, st);
   endfunction

   // driver tasks
   task automatic drive(input step_t s);
      rst          = s.rst;
      id_rs        = s.rs;
      id_rt        = s.rt;
      ex_rd        = s.rd;
      id_uses_rt   = s.urt;
      ex_mem_read  = s.mr;
      mem_req      = s.req;
      mem_ack      = s.ack;
      branch_taken = s.br;
      exp_q.push_back(s.exp);
   endtask

   task automatic apply_reset();
      rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      step_t t[$];
      logic [9:0] e;
      repeat (2) t.push_back(mk(1, 5, 0, 5, 0, 1, 1, 0, 0, C_NONE, 0, S_RUN));
      t.push_back(mk(0, 5, 0, 5, 0, 1, 1, 0, 0, C_ALL, 0, S_RUN));
      t.push_back(mk(0, 5, 0, 5, 0, 1, 1, 0, 0, C_ALL, 0, S_MW));
      t.push_back(mk(1, 5, 0, 5, 0, 1, 1, 0, 0, C_NONE, 0, S_RUN));
      t.push_back(idle(S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got1 !== e) $display("FAIL reset step %0d: got %b expected %b", i, got1, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      step_t t[$];
      logic [9:0] e;
      logic [4:0] rs, rt, rd;
      logic urt, mr, hit;
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(idle(S_RUN));
      t.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, C_NONE, 0, S_RUN));
      t.push_back(mk(0, 3, 7, 7, 1, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(mk(0, 3, 7, 7, 0, 1, 0, 0, 0, C_NONE, 0, S_RUN));
      t.push_back(mk(0, 5, 0, 5, 0, 0, 0, 0, 0, C_NONE, 0, S_RUN));
      for (int k = 0; k < 10; k++) begin
         rs  = 5'($urandom_range(0, 7));
         rt  = 5'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 7));
         urt = 1'($urandom_range(0, 1));
         mr  = 1'($urandom_range(0, 1));
         hit = mr && (rd != 5'd0) && ((rd == rs) || (urt && (rd == rt)));
         t.push_back(mk(0, rs, rt, rd, urt, mr, 0, 0, 0, hit ? C_BUB : C_NONE, 0, S_RUN));
      end
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got1 !== e) $display("FAIL load_use step %0d: got %b expected %b", i, got1, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use_multi();
      step_t t[$];
      logic [9:0] e;
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(idle(S_LU));
      t[$].exp = {C_BUB, 1'b0, S_LU};
      t.push_back(idle(S_LU));
      t[$].exp = {C_BUB, 1'b0, S_LU};
      t.push_back(idle(S_RUN));
      // reset in the middle of a bubble sequence abandons it
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, S_RUN));
      t.push_back(idle(S_RUN));
      // memory stall during LOAD_USE drops the bubbles
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_LU));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 0, S_MW));
      t.push_back(idle(S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got3 !== e) $display("FAIL load_use3 step %0d: got %b expected %b", i, got3, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      step_t t[$];
      logic [9:0] e;
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_MW));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, C_ALL, 0, S_MW));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_MW));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 0, S_MW));
      t.push_back(idle(S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 0, S_RUN));
      t.push_back(idle(S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got1 !== e) $display("FAIL mem_wait step %0d: got %b expected %b", i, got1, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      step_t t[$];
      logic [9:0] e;
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_RUN));
      for (int k = 0; k < 15; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_MW));
      for (int k = 0; k < 3; k++) t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 1, 1, C_ALL, 1, S_ERR));
      t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 0, S_RUN));
      t.push_back(idle(S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got1 !== e) $display("FAIL timeout step %0d: got %b expected %b", i, got1, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout_ack();
      step_t t[$];
      logic [9:0] e;
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_RUN));
      for (int k = 0; k < 14; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_MW));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 0, S_MW));
      t.push_back(idle(S_RUN));
      t.push_back(idle(S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got1 !== e) $display("FAIL timeout_ack step %0d: got %b expected %b", i, got1, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      step_t t[$];
      logic [9:0] e;
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 1, C_FLU, 0, S_RUN));
      t.push_back(idle(S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLU, 0, S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, C_ALL, 0, S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, C_ALL, 0, S_MW));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 0, S_MW));
      t.push_back(idle(S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_FLU, 0, S_RUN));
      t.push_back(idle(S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_total++;
         if (got1 !== e) $display("FAIL branch step %0d: got %b expected %b", i, got1, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      step_t t[$];
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_RUN));
      for (int k = 0; k < 3; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_ALL, 0, S_MW));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 0, S_MW));
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(idle(S_RUN));
      t.push_back(mk(0, 5, 0, 5, 0, 1, 0, 0, 0, C_BUB, 0, S_RUN));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLU, 0, S_RUN));
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         void'(exp_q.pop_front());
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_total++;
      if (pms1 !== 32'd4) $display("FAIL perf_mem_stall: got %0d expected 4", pms1);
      else n_pass++;
      n_total++;
      if (plb1 !== 32'd2) $display("FAIL perf_lu_bubble: got %0d expected 2", plb1);
      else n_pass++;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      apply_reset();
      test_reset();
      apply_reset();
      test_load_use();
      apply_reset();
      test_load_use_multi();
      apply_reset();
      test_mem_wait();
      apply_reset();
      test_timeout();
      apply_reset();
      test_timeout_ack();
      apply_reset();
      test_branch();
`ifdef HAZARD_PERF_CNT_EN
      apply_reset();
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Drives the `stall` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the flush and PC-hold controls. It handles three hazards: multi-cycle data-memory access (req/ack handshake), load-use data hazards, and taken-branch flushes. It also watches memory access for a timeout and latches a sticky error.

Parameters:
REG_ADDR_W, 5, register-file address width
BUBBLE_CYCLES, 1, bubbles inserted per load-use hazard (range 1..7)
MEM_TIMEOUT, 15, MEM_WAIT cycles without ack before error (range 1..255)

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  synchronous active-high reset
id_rs  in  REG_ADDR_W  ID-stage source reg 1
id_rt  in  REG_ADDR_W  ID-stage source reg 2
id_uses_rt  in  1  ID instruction reads id_rt
ex_mem_read  in  1  EX-stage instruction is a load
ex_rd  in  REG_ADDR_W  EX-stage destination reg
mem_req  in  1  MEM stage has a data-memory access this cycle
mem_ack  in  1  data memory completes access this cycle
branch_taken  in  1  EX resolved a taken branch/jump
stall_if_id  out  1  hold IF/ID latch
stall_id_ex  out  1  hold ID/EX latch
stall_ex_mem  out  1  hold EX/MEM latch
stall_mem_wb  out  1  hold MEM/WB latch
flush_if_id  out  1  clear IF/ID to NOP
flush_id_ex  out  1  clear ID/EX to NOP (bubble)
pc_hold  out  1  PC not updated
mem_timeout_err  out  1  sticky memory-timeout flag
ctrl_state  out  2  00 RUN, 01 LOAD_USE, 10 MEM_WAIT, 11 ERR

Behaviour:
- Reset: state=RUN, bubble_cnt=0, wait_cnt=0, mem_timeout_err=0. While rst=1, every output is forced to 0 regardless of the other inputs. Reset mid-MEM_WAIT or mid-LOAD_USE abandons the operation.
- Outputs are combinational from the current state and inputs, so they take effect in the same cycle. State and counters are registered.
- `memstall` = mem_req & ~mem_ack, evaluated in RUN or LOAD_USE, or state==MEM_WAIT & ~mem_ack.
- `lu_hit` = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Priority in RUN: memstall > branch_taken > lu_hit.
- RUN:
  - memstall: all four stalls=1 and pc_hold=1; next state MEM_WAIT with wait_cnt=1.
  - Else branch_taken: flush_if_id=1 and flush_id_ex=1, no stalls; stay RUN. A branch coinciding with lu_hit flushes with no bubble.
  - Else lu_hit: stall_if_id=1, pc_hold=1, flush_id_ex=1. If BUBBLE_CYCLES>1, next state LOAD_USE with bubble_cnt=BUBBLE_CYCLES-1.
  - Else all outputs 0.
- LOAD_USE: same outputs as the lu_hit cycle. bubble_cnt decrements each cycle; at 1, next state RUN. memstall here overrides: all stalls=1, flush_id_ex=0, next state MEM_WAIT, and the remaining bubbles are dropped.
- MEM_WAIT:
  - ~mem_ack: all stalls=1, pc_hold=1, wait_cnt++.
  - mem_ack: all stalls=0 in that same cycle; next state RUN.
  - wait_cnt==MEM_TIMEOUT & ~mem_ack: next state ERR.
  - Ack on the very cycle the timeout is reached wins; no error.
- ERR: all stalls=1, pc_hold=1, mem_timeout_err=1. Left only by rst.
- Flushes are never asserted while stall_mem_wb=1.
- A branch in EX during MEM_WAIT is held by the EX/MEM stall and acted on after ack.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_mem_stall[31:0] and perf_lu_bubble[31:0].
  - perf_mem_stall counts cycles with stall_mem_wb=1.
  - perf_lu_bubble counts cycles with flush_id_ex=1 & ~branch_taken.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Not defined: the ports and the counters are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles while mem_req=1, mem_ack=0, lu_hit true -> every output 0, ctrl_state=00. After release, stalls assert in the first non-reset cycle.
- ex_mem_read=1, ex_rd=5, id_rs=5, BUBBLE_CYCLES=1 -> exactly 1 cycle of stall_if_id=pc_hold=flush_id_ex=1, then all 0. With ex_rd=0 -> no bubble. With BUBBLE_CYCLES=3 -> 3 bubble cycles, ctrl_state 01 for 2 cycles.
- mem_req=1, mem_ack low for 4 cycles then high -> all stalls high for 4 cycles, low on the ack cycle, ctrl_state back to 00 the next cycle.
- MEM_TIMEOUT=15, mem_ack never asserted -> ctrl_state=11 after 15 MEM_WAIT cycles, mem_timeout_err=1 and held until rst. Separate case: ack on cycle 15 -> no error.
- branch_taken=1 together with lu_hit -> flush_if_id=flush_id_ex=1, stall_if_id=0. branch_taken together with mem_req & ~mem_ack -> stalls only, flushes 0.
- HAZARD_PERF_CNT_EN: 4-cycle memory wait plus 2 load-use bubbles -> perf_mem_stall=4, perf_lu_bubble=2. Preload near max -> saturates at 0xFFFFFFFF.
